// File: rtl/hc595_pkg.sv
// hc595_pkg: shared definitions for the 74HC595 chain driver.
//   - hc595_state_e : driver FSM states
//   - DEF_*         : default parameter values
//   - frame_cycles  : clk cycles from one accept to the next possible accept
package hc595_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SH_LO,
    SH_HI,
    LT_LO,
    LT_HI
  } hc595_state_e;

  localparam int unsigned DEF_CHAIN_LEN = 2;
  localparam int unsigned DEF_DIV       = 2;
  localparam int unsigned DEF_MSB_FIRST = 1;
  localparam int unsigned DEF_PWM_W     = 8;

  // W data bits plus one latch pulse, each a full sh_cp/st_cp period of
  // 2*DIV cycles, plus the single idle cycle in which the accept happens.
  function automatic int unsigned frame_cycles(input int unsigned div,
                                               input int unsigned w);
    return 2 * div * (w + 1) + 1;
  endfunction

endpackage

// File: rtl/hc595_tick_div.sv
// hc595_tick_div: DIV-cycle tick generator pacing the driver FSM.
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   restart_i : restart the count so the next tick is DIV cycles away
//   tick_o    : high in the last cycle of every DIV-cycle period
module hc595_tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic tick_o
);

  // DIV=1 would give a zero-width counter; keep one bit that never moves.
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serial driver for CHAIN_LEN cascaded 74HC595s.
// Accepts a W=8*CHAIN_LEN bit frame over valid/ready, shifts it out on
// ds/sh_cp (MSB or LSB first), then pulses st_cp to latch all outputs.
//   clk, reset        : clock, synchronous active-high reset
//   chip_en           : enable; low aborts a frame and disables outputs
//   in_data/in_valid  : frame and its valid; in_ready = idle and enabled
//   busy              : frame in progress
//   pwm_duty          : brightness duty (only with HC595_OE_PWM_EN)
//   ds, sh_cp, st_cp  : serial data, shift clock, storage clock
//   oe_n              : active-low output enable
// Optional feature macro: HC595_OE_PWM_EN (PWM dimming on oe_n).
// All outputs are registered.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned MSB_FIRST = DEF_MSB_FIRST,
  parameter int unsigned PWM_W     = DEF_PWM_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chip_en,
  input  logic [8*CHAIN_LEN-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   busy,
  input  logic [PWM_W-1:0]       pwm_duty,
  output logic                   ds,
  output logic                   sh_cp,
  output logic                   st_cp,
  output logic                   oe_n
);

  localparam int unsigned W  = 8 * CHAIN_LEN;
  localparam int unsigned BW = $clog2(W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  hc595_state_e  state_q;
  logic [W-1:0]  shreg_q;
  logic [BW-1:0] bitcnt_q;
  logic          ds_q, sh_q, st_q, busy_q, rdy_q, oe_n_q;

  logic          tick;
  logic          accept;
  logic          abort;
  logic [W-1:0]  shreg_shift;

  assign accept = in_valid && rdy_q;
  assign abort  = !chip_en && (state_q != IDLE);

  // Outgoing bit sits at the end selected by MSB_FIRST; shift toward it.
  assign shreg_shift = (MSB_FIRST != 0) ? {shreg_q[W-2:0], 1'b0}
                                        : {1'b0, shreg_q[W-1:1]};

  function automatic logic first_bit(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction

  // Restart on accept and abort so every state lasts exactly DIV cycles.
  hc595_tick_div #(
    .DIV(DIV)
  ) u_tick (
    .clk_i    (clk),
    .reset_i  (reset),
    .restart_i(accept || abort),
    .tick_o   (tick)
  );

  // Outputs are assigned on the transition into each state so that they
  // are registered yet aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      ds_q     <= 1'b0;
      sh_q     <= 1'b0;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      ds_q     <= 1'b0;
      sh_q     <= 1'b0;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= chip_en;
          if (accept) begin
            shreg_q  <= in_data;
            bitcnt_q <= '0;
            state_q  <= SH_LO;
            busy_q   <= 1'b1;
            rdy_q    <= 1'b0;
            sh_q     <= 1'b0;
            st_q     <= 1'b0;
            ds_q     <= first_bit(in_data);
          end
        end
        SH_LO: begin
          if (tick) begin
            state_q <= SH_HI;
            sh_q    <= 1'b1;
          end
        end
        SH_HI: begin
          if (tick) begin
            shreg_q  <= shreg_shift;
            bitcnt_q <= bitcnt_q + 1'b1;
            sh_q     <= 1'b0;
            if (bitcnt_q == LAST_BIT) begin
              state_q <= LT_LO;
              ds_q    <= 1'b0;
              st_q    <= 1'b0;
            end else begin
              state_q <= SH_LO;
              ds_q    <= first_bit(shreg_shift);
            end
          end
        end
        LT_LO: begin
          if (tick) begin
            state_q <= LT_HI;
            st_q    <= 1'b1;
          end
        end
        LT_HI: begin
          if (tick) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= chip_en;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HC595_OE_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  // Free-running counter; duty 0 keeps oe_n high, all-ones leaves one
  // off cycle per period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      oe_n_q    <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      oe_n_q    <= ~(chip_en && (pwm_cnt_q < pwm_duty));
    end
  end
`else
  // pwm_duty is kept on the port for a stable interface only.
  logic unused_pwm;
  assign unused_pwm = ^pwm_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      oe_n_q <= 1'b1;
    end else begin
      oe_n_q <= ~chip_en;
    end
  end
`endif

  assign ds       = ds_q;
  assign sh_cp    = sh_q;
  assign st_cp    = st_q;
  assign busy     = busy_q;
  assign in_ready = rdy_q;
  assign oe_n     = oe_n_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver (CHAIN_LEN=2, DIV=2). Two
// instances share all inputs: one MSB-first, one LSB-first.
// Cycle n is the interval after clock edge n-1, with edge 0 the accept.
module tb_hc595_chain_driver;
  import hc595_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chip_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  pwm_duty = '0;

  logic in_ready, busy, ds, sh_cp, st_cp, oe_n;
  logic in_ready_l, busy_l, ds_l, sh_cp_l, st_cp_l, oe_n_l;

  int tests = 0;
  int fails = 0;

  logic [15:0] cap_m, cap_l;
  int nrise, st_cyc, nst, nsthi, rdy_cyc, both, low, frame_len;

  always #5 clk = ~clk;

  hc595_chain_driver #(
    .CHAIN_LEN(2), .DIV(2), .MSB_FIRST(1), .PWM_W(8)
  ) dut (
    .clk(clk), .reset(reset), .chip_en(chip_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .pwm_duty(pwm_duty), .ds(ds), .sh_cp(sh_cp), .st_cp(st_cp), .oe_n(oe_n)
  );

  hc595_chain_driver #(
    .CHAIN_LEN(2), .DIV(2), .MSB_FIRST(0), .PWM_W(8)
  ) dut_lsb (
    .clk(clk), .reset(reset), .chip_en(chip_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_l), .busy(busy_l),
    .pwm_duty(pwm_duty), .ds(ds_l), .sh_cp(sh_cp_l), .st_cp(st_cp_l),
    .oe_n(oe_n_l)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples cycles 1..ncyc starting at the current sample point; ds is
  // captured at every sh_cp rise with the first bit ending in the MSB.
  task automatic observe(input int ncyc, input int chg_at,
                         input logic [15:0] chg_data);
    logic psh, pshl, pst;
    cap_m = '0; cap_l = '0; nrise = 0; st_cyc = -1; nst = 0; nsthi = 0;
    rdy_cyc = -1; both = 0;
    psh = 1'b0; pshl = 1'b0; pst = 1'b0;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      if (c == chg_at) in_data = chg_data;
      if (sh_cp && !psh) begin
        nrise++;
        cap_m = {cap_m[14:0], ds};
      end
      if (sh_cp_l && !pshl) cap_l = {cap_l[14:0], ds_l};
      if (st_cp && !pst) begin
        nst++;
        if (st_cyc < 0) st_cyc = c;
      end
      if (st_cp) nsthi++;
      if (in_ready && rdy_cyc < 0) rdy_cyc = c;
      if (in_ready && busy) both++;
      psh = sh_cp; pshl = sh_cp_l; pst = st_cp;
      if (c < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    frame_len = int'(frame_cycles(2, 16));

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ds", ds, 1'b0);
    check("rst_sh_cp", sh_cp, 1'b0);
    check("rst_st_cp", st_cp, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_oe_n", oe_n, 1'b1);

    reset = 1'b0;
    chip_en = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_oe_n", oe_n, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Frame 1: 16'hAF65
    in_valid = 1'b1;
    in_data = 16'hAF65;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("f1_busy_c1", busy, 1'b1);
    check("f1_ready_c1", in_ready, 1'b0);
    check("f1_ds_c1", ds, 1'b1);
    observe(frame_len, 0, 16'h0000);
    check("f1_rises", nrise, 16);
    check("f1_msb_bits", cap_m, 16'hAF65);
    check("f1_lsb_bits", cap_l, 16'hA6F5);
    check("f1_st_cycle", st_cyc, 67);
    check("f1_st_pulses", nst, 1);
    check("f1_st_width", nsthi, 2);
    check("f1_ready_cycle", rdy_cyc, 69);
    check("f1_ready_busy", both, 0);

    // Frame 2: 16'h55A5
    in_valid = 1'b1;
    in_data = 16'h55A5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    observe(frame_len, 0, 16'h0000);
    check("f2_msb_bits", cap_m, 16'h55A5);
    check("f2_lsb_bits", cap_l, 16'hA5AA);
    check("f2_ready_cycle", rdy_cyc, 69);

    // Frame 3: in_valid held, data changed mid-frame
    in_valid = 1'b1;
    in_data = 16'h3C96;
    @(posedge clk);
    #1;
    observe(frame_len, 10, 16'h0001);
    check("f3_msb_bits", cap_m, 16'h3C96);
    check("f3_st_pulses", nst, 1);
    check("f3_ready_cycle", rdy_cyc, 69);
    check("f3_ready_busy", both, 0);

    // Frame 4: accepted at cycle 69 of frame 3
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("f4_busy_c1", busy, 1'b1);
    observe(frame_len, 0, 16'h0000);
    check("f4_msb_bits", cap_m, 16'h0001);
    check("f4_lsb_bits", cap_l, 16'h8000);

    // Frame 5: chip_en dropped at cycle 20
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    observe(19, 0, 16'h0000);
    check("f5_sh_cp_c19", sh_cp, 1'b1);
    @(posedge clk);
    #1;
    chip_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sh_cp", sh_cp, 1'b0);
    check("abort_st_cp", st_cp, 1'b0);
    check("abort_ds", ds, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_oe_n", oe_n, 1'b1);
    check("abort_in_ready", in_ready, 1'b0);
    observe(40, 0, 16'h0000);
    check("abort_st_pulses", nst, 0);
    chip_en = 1'b1;
    @(posedge clk);
    #1;
    check("reen_in_ready", in_ready, 1'b1);
    check("reen_oe_n", oe_n, 1'b0);

    // Frame 6: reset at cycle 30
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    observe(29, 0, 16'h0000);
    check("f6_busy_c29", busy, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ds", ds, 1'b0);
    check("midrst_sh_cp", sh_cp, 1'b0);
    check("midrst_st_cp", st_cp, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_oe_n", oe_n, 1'b1);
    reset = 1'b0;
    observe(80, 0, 16'h0000);
    check("midrst_st_pulses", nst, 0);
    check("midrst_ready_after", in_ready, 1'b1);

    // Output enable / PWM
`ifdef HC595_OE_PWM_EN
    pwm_duty = 8'd64;
    repeat (2) @(posedge clk);
    low = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (!oe_n) low++;
    end
    check("pwm64_low_cycles", low, 64);
    pwm_duty = 8'd0;
    repeat (2) @(posedge clk);
    low = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (!oe_n) low++;
    end
    check("pwm0_low_cycles", low, 0);
`else
    pwm_duty = 8'd64;
    repeat (2) @(posedge clk);
    low = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (!oe_n) low++;
    end
    check("oe_static_low_cycles", low, 256);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
